// File: rtl/bus_arb_rr.sv
// Multi-host to multi-device bus with address decode and single-cycle response routing.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest host index wins.
module bus_arb_rr #(
   parameter int unsigned NrHosts      = 2,
   parameter int unsigned NrDevices    = 3,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned AddressWidth = 32
) (
   input  logic                              clk_i,
   input  logic                              rst_i,

   input  logic [NrHosts-1:0]                host_req_i,
   output logic [NrHosts-1:0]                host_gnt_o,
   input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
   input  logic [NrHosts-1:0]                host_we_i,
   input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
   input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
   output logic [NrHosts-1:0]                host_rvalid_o,
   output logic [NrHosts*DataWidth-1:0]      host_rdata_o,
   output logic [NrHosts-1:0]                host_err_o,

   output logic [NrDevices-1:0]              device_req_o,
   output logic [NrDevices*AddressWidth-1:0] device_addr_o,
   output logic [NrDevices-1:0]              device_we_o,
   output logic [NrDevices*DataWidth/8-1:0]  device_be_o,
   output logic [NrDevices*DataWidth-1:0]    device_wdata_o,
   input  logic [NrDevices-1:0]              device_rvalid_i,
   input  logic [NrDevices*DataWidth-1:0]    device_rdata_i,
   input  logic [NrDevices-1:0]              device_err_i,

   input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_base_i,
   input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_mask_i
);

   localparam int unsigned HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
   localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
   localparam int unsigned BeW      = DataWidth / 8;

   logic                    gnt_valid;
   logic [HostIdxW-1:0]     gnt_idx;
   int unsigned             win;
   int unsigned             cand;
   int unsigned             start;
   logic [AddressWidth-1:0] win_addr;
   logic                    dev_hit;
   int unsigned             dev_sel;

   logic                    pend_q, pend_d;
   logic                    miss_q, miss_d;
   logic [HostIdxW-1:0]     host_q, host_d;
   logic [DevIdxW-1:0]      dev_q, dev_d;

`ifdef BUS_ARB_ROUND_ROBIN_EN
   logic [HostIdxW-1:0]     rr_q, rr_d;

   always_comb begin
      rr_d = rr_q;
      if (gnt_valid) begin
         rr_d = HostIdxW'((win + 1) % NrHosts);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end

   assign start = int'(rr_q);
`else
   assign start = 0;
`endif

   // Arbitration: first requester found searching upward from start, wrapping.
   always_comb begin
      gnt_valid  = 1'b0;
      gnt_idx    = '0;
      win        = 0;
      cand       = 0;
      host_gnt_o = '0;
      for (int unsigned i = 0; i < NrHosts; i++) begin
         cand = (start + i) % NrHosts;
         if (!gnt_valid && !rst_i && host_req_i[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = HostIdxW'(cand);
            win       = cand;
         end
      end
      if (gnt_valid) begin
         host_gnt_o[win] = 1'b1;
      end
   end

   // Decode: lowest-index matching device wins.
   always_comb begin
      win_addr = host_addr_i[win*AddressWidth +: AddressWidth];
      dev_hit  = 1'b0;
      dev_sel  = 0;
      for (int unsigned d = 0; d < NrDevices; d++) begin
         if (!dev_hit && ((win_addr & cfg_device_addr_mask_i[d*AddressWidth +: AddressWidth]) ==
                          cfg_device_addr_base_i[d*AddressWidth +: AddressWidth])) begin
            dev_hit = 1'b1;
            dev_sel = d;
         end
      end
   end

   always_comb begin
      device_req_o   = '0;
      device_addr_o  = '0;
      device_we_o    = '0;
      device_be_o    = '0;
      device_wdata_o = '0;
      if (gnt_valid && dev_hit) begin
         device_req_o[dev_sel]                                = 1'b1;
         device_addr_o[dev_sel*AddressWidth +: AddressWidth]  = win_addr;
         device_we_o[dev_sel]                                 = host_we_i[win];
         device_be_o[dev_sel*BeW +: BeW]                      = host_be_i[win*BeW +: BeW];
         device_wdata_o[dev_sel*DataWidth +: DataWidth]       =
            host_wdata_i[win*DataWidth +: DataWidth];
      end
   end

   always_comb begin
      pend_d = gnt_valid;
      host_d = host_q;
      dev_d  = dev_q;
      miss_d = miss_q;
      if (gnt_valid) begin
         host_d = gnt_idx;
         dev_d  = DevIdxW'(dev_sel);
         miss_d = !dev_hit;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_q <= 1'b0;
         host_q <= '0;
         dev_q  <= '0;
         miss_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
         host_q <= host_d;
         dev_q  <= dev_d;
         miss_q <= miss_d;
      end
   end

   // Responses pass straight through from the tracked device; misses answer with an error.
   always_comb begin
      host_rvalid_o = '0;
      host_err_o    = '0;
      host_rdata_o  = '0;
      if (pend_q) begin
         if (miss_q) begin
            host_rvalid_o[host_q] = 1'b1;
            host_err_o[host_q]    = 1'b1;
         end else begin
            host_rvalid_o[host_q] = device_rvalid_i[dev_q];
            host_err_o[host_q]    = device_err_i[dev_q];
            host_rdata_o[int'(host_q)*DataWidth +: DataWidth] =
               device_rdata_i[int'(dev_q)*DataWidth +: DataWidth];
         end
      end
   end

endmodule

// File: tb/tb_bus_arb_rr.sv
// Directed bench for bus_arb_rr: 3 hosts, devices RAM / SimCtrl / Timer with 1-cycle response.
module tb_bus_arb_rr;
   localparam int unsigned NH = 3;
   localparam int unsigned ND = 3;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;

   localparam logic [31:0] RamRd  = 32'hDEAD_BEEF;
   localparam logic [31:0] SimRd  = 32'h5117_C7A1;
   localparam logic [31:0] TmrRd  = 32'h7133_0001;
   localparam logic [31:0] RamA   = 32'h0010_0040;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [NH-1:0]      host_req, host_gnt, host_we, host_rvalid, host_err;
   logic [NH*AW-1:0]   host_addr;
   logic [NH*DW/8-1:0] host_be;
   logic [NH*DW-1:0]   host_wdata, host_rdata;
   logic [ND-1:0]      dev_req, dev_we, dev_err;
   logic [ND-1:0]      dev_rvalid = '0;
   logic [ND*AW-1:0]   dev_addr, cfg_base, cfg_mask;
   logic [ND*DW/8-1:0] dev_be;
   logic [ND*DW-1:0]   dev_wdata, dev_rdata;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   logic [2:0] exp_gnt [6];
   logic [2:0] exp_second;

   always #5 clk = ~clk;

   // Device model: every device answers exactly one cycle after a request.
   always @(posedge clk) dev_rvalid <= dev_req;
   assign dev_rdata = {TmrRd, SimRd, RamRd};
   assign dev_err   = 3'b100;
   assign cfg_base  = {32'h0003_0000, 32'h0002_0000, 32'h0010_0000};
   assign cfg_mask  = {32'hFFFF_FC00, 32'hFFFF_FC00, 32'hFFF0_0000};

   bus_arb_rr #(
      .NrHosts     (NH),
      .NrDevices   (ND),
      .DataWidth   (DW),
      .AddressWidth(AW)
   ) u_dut (
      .clk_i                 (clk),
      .rst_i                 (rst),
      .host_req_i            (host_req),
      .host_gnt_o            (host_gnt),
      .host_addr_i           (host_addr),
      .host_we_i             (host_we),
      .host_be_i             (host_be),
      .host_wdata_i          (host_wdata),
      .host_rvalid_o         (host_rvalid),
      .host_rdata_o          (host_rdata),
      .host_err_o            (host_err),
      .device_req_o          (dev_req),
      .device_addr_o         (dev_addr),
      .device_we_o           (dev_we),
      .device_be_o           (dev_be),
      .device_wdata_o        (dev_wdata),
      .device_rvalid_i       (dev_rvalid),
      .device_rdata_i        (dev_rdata),
      .device_err_i          (dev_err),
      .cfg_device_addr_base_i(cfg_base),
      .cfg_device_addr_mask_i(cfg_mask)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int h, input logic [31:0] addr, input logic we);
      host_req[h]           = 1'b1;
      host_addr[h*AW +: AW] = addr;
      host_we[h]            = we;
   endtask

   initial begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
      exp_gnt    = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      exp_second = 3'b100;
`else
      exp_gnt    = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
      exp_second = 3'b001;
`endif
      host_req   = '0;
      host_addr  = '0;
      host_we    = '0;
      host_be    = '1;
      host_wdata = '0;

      // Reset with a live request: everything must stay quiet.
      set_req(0, RamA, 1'b0);
      repeat (2) @(posedge clk);
      #4;
      chk("rst_gnt", host_gnt, 0);
      chk("rst_dev_req", dev_req, 0);
      chk("rst_rvalid", host_rvalid, 0);
      chk("rst_err", host_err, 0);
      chk("rst_rdata", host_rdata, 0);

      // Single host read to RAM.
      next_cycle();
      rst = 1'b0;
      #3;
      chk("rd_gnt", host_gnt, 3'b001);
      chk("rd_dev_req", dev_req, 3'b001);
      chk("rd_dev_addr", dev_addr, {64'h0, RamA});

      // Decode miss from host 1, issued in the RAM response cycle.
      next_cycle();
      host_req = '0;
      set_req(1, 32'h0005_0000, 1'b1);
      host_wdata[DW +: DW] = 32'hCAFE_F00D;
      #3;
      chk("rd_rvalid", host_rvalid, 3'b001);
      chk("rd_rdata", host_rdata, {64'h0, RamRd});
      chk("rd_err", host_err, 3'b000);
      chk("miss_gnt", host_gnt, 3'b010);
      chk("miss_dev_req", dev_req, 3'b000);
      chk("miss_dev_wdata", dev_wdata, 0);
      next_cycle();
      host_req = '0;
      #3;
      chk("miss_rvalid", host_rvalid, 3'b010);
      chk("miss_err", host_err, 3'b010);
      chk("miss_rdata", host_rdata, 0);

      // Short reset pulse returns the pointer to host 0, then all hosts contend.
      rst = 1'b1;
      #2;
      rst = 1'b0;
      next_cycle();
      set_req(0, RamA, 1'b0);
      set_req(1, RamA, 1'b0);
      set_req(2, RamA, 1'b0);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) next_cycle();
         #3;
         chk($sformatf("arb_gnt%0d", k), host_gnt, exp_gnt[k]);
         if (k > 0) chk($sformatf("arb_rvalid%0d", k), host_rvalid, exp_gnt[k-1]);
      end
      next_cycle();
      host_req = '0;
      #3;
      chk("arb_rvalid_last", host_rvalid, exp_gnt[5]);

      // Back-to-back SimCtrl then Timer from host 0.
      next_cycle();
      set_req(0, 32'h0002_0004, 1'b0);
      #3;
      chk("b2b_gnt", host_gnt, 3'b001);
      chk("b2b_dev_req0", dev_req, 3'b010);
      next_cycle();
      set_req(0, 32'h0003_0008, 1'b0);
      #3;
      chk("b2b_dev_req1", dev_req, 3'b100);
      chk("b2b_rvalid1", host_rvalid, 3'b001);
      chk("b2b_rdata1", host_rdata, {64'h0, SimRd});
      chk("b2b_err1", host_err, 3'b000);
      next_cycle();
      host_req = '0;
      #3;
      chk("b2b_rvalid2", host_rvalid, 3'b001);
      chk("b2b_rdata2", host_rdata, {64'h0, TmrRd});
      chk("b2b_err2", host_err, 3'b001);

      // Reset in the middle of a granted transaction.
      next_cycle();
      set_req(0, RamA, 1'b0);
      #3;
      chk("mid_gnt", host_gnt, 3'b001);
      #1;
      rst = 1'b1;
      host_req = '0;
      next_cycle();
      #3;
      chk("mid_rvalid", host_rvalid, 3'b000);
      chk("mid_gnt_rst", host_gnt, 3'b000);
      #1;
      rst = 1'b0;
      set_req(0, RamA, 1'b0);
      set_req(2, RamA, 1'b0);
      #2;
      chk("post_rst_first", host_gnt, 3'b001);
      next_cycle();
      #3;
      chk("post_rst_second", host_gnt, exp_second);
      next_cycle();
      host_req = '0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bus_arb_rr.md
# bus_arb_rr

Parametrised multi-host to multi-device memory bus for the simple-system family. It extends the single-host address-decoding bus to N hosts with round-robin arbitration and decode-miss error responses. It sits between the core data port, further hosts such as DMA or a debug module, and the SRAM, sim-control and timer devices. Devices must be single-cycle-response: rvalid one cycle after an accepted req.

## Interface
Parameters:
- NrHosts, 2: number of host ports (1..16).
- NrDevices, 3: number of device ports (1..16).
- DataWidth, 32: data width in bits.
- AddressWidth, 32: address width in bits.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- host_req_i / host_gnt_o  in/out  [NrHosts] x 1  request / grant.
- host_addr_i  in  [NrHosts] x AddressWidth  byte address.
- host_we_i, host_be_i, host_wdata_i  in  [NrHosts] x 1 / DataWidth/8 / DataWidth  write enable, byte enables, write data.
- host_rvalid_o, host_rdata_o, host_err_o  out  [NrHosts] x 1 / DataWidth / 1  response.
- device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o  out  [NrDevices] x matching widths  forwarded request.
- device_rvalid_i, device_rdata_i, device_err_i  in  [NrDevices] x 1 / DataWidth / 1  device response.
- cfg_device_addr_base_i, cfg_device_addr_mask_i  in  [NrDevices] x AddressWidth  decode config; device d hits when (addr & mask[d]) == base[d].

## Operation
- Arbitration: among hosts with host_req_i=1, exactly one winner per cycle. host_gnt_o=1 only for the winner, combinational in the same cycle.
- Round-robin pointer rr_q, width $clog2(NrHosts) (min 1). The search starts at rr_q and wraps modulo NrHosts.
- On a grant to host h, rr_q <= (h+1) mod NrHosts. With no grant, rr_q holds.
- Decode: the winner's address is compared against all devices. If several match, the lowest-index device wins.
- On hit to device d: device_req_o[d]=1 and addr/we/be/wdata are copied from the winner. All other device_req_o are 0. Device payload outputs for non-selected devices are 0.
- On miss: the host is still granted, and no device_req_o is asserted.
- Response tracking register, set on every grant: pend_q, host_q, dev_q, miss_q.
- Cycle after grant:
  - Hit: host_rvalid_o[host_q] = device_rvalid_i[dev_q]; rdata and err are taken from dev_q.
  - Miss: host_rvalid_o[host_q]=1, host_err_o=1, host_rdata_o=0.
- Non-addressed hosts see rvalid/err/rdata = 0.
- device_rvalid_i with no pending tracked transaction to that device is ignored.
- Back-to-back: a new grant can occur in the same cycle as the previous response. Throughput is 1 transaction per cycle.

## Timing
- Grant and device request: 0 cycles from host_req_i (combinational).
- Response: exactly 1 cycle after grant. Host responses are combinational from device_rvalid_i in that cycle; no extra register stage.
- Reset values: rr_q=0, pend_q=0. All host_gnt_o, host_rvalid_o, host_err_o, device_req_o are 0, and rdata is 0 during reset.
- Reset asserted mid-transaction: pend_q clears asynchronously. The in-flight response is dropped, and no host_rvalid_o is asserted in the following cycle.
- host_req_i deasserted while not granted is legal; that host is simply skipped.
- NrHosts=1: arbitration degenerates to pass-through and rr_q is constant 0.

## Configuration
- Macro BUS_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration as described.
- Undefined: fixed priority, lowest host index wins. rr_q is not implemented and the search always starts at host 0.
- Decode, response routing and timing are identical in both builds.

## Test plan
- Single host 0, read to 0x0010_0040 with RAM base 0x0010_0000 and mask ~0xFFFFF:
  - Cycle 0: gnt[0]=1, device_req[0]=1.
  - Cycle 1: RAM returns 0xDEADBEEF, so host_rvalid[0]=1, rdata=0xDEADBEEF, err=0.
- Decode miss, host 1 writes 0x0005_0000:
  - Cycle 0: gnt[1]=1, no device_req.
  - Cycle 1: rvalid[1]=1, err[1]=1, rdata=0.
- Round robin, NrHosts=3, all hosts requesting continuously for 6 cycles:
  - Grant order 0,1,2,0,1,2.
  - With the macro undefined: 0,0,0,0,0,0.
- Back-to-back, host 0 reads SimCtrl then Timer in consecutive cycles:
  - Responses arrive in cycles 1 and 2, each with the correct device rdata.
  - Timer device_err=1 is propagated to host_err[0].
- Reset mid-operation: grant in cycle 0, rst_i asserted in cycle 0.5 for one cycle:
  - No host_rvalid in cycle 1.
  - After release, rr_q=0, so host 0 wins the first contention against host 2.
